// File: rtl/uart_rx_cfg_pkg.sv
// uart_rx_cfg_pkg: shared FSM states and frame constants for the configurable UART receiver
package uart_rx_cfg_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER} state_t;
  localparam int MIN_DATA_LEN = 5;
  localparam int MIN_PRESCALE = 6;
  localparam int SAMPLE_PRE = 1;
  localparam int SAMPLE_POST = 1;
endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// uart_rx_cfg_sampler: per-bit edge counter with 3-point majority vote around mid-bit
module uart_rx_cfg_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      rx,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_valid,
  output logic                      bit_value,
  output logic                      bit_end
);
  logic [PRESCALE_WIDTH-1:0] cnt, half, last;
  logic s_lo, s_mid;
  always_comb begin
    half = prescale >> 1;
    last = prescale - PRESCALE_WIDTH'(1);
    bit_end = run && cnt == last;
    bit_valid = run && cnt == half + PRESCALE_WIDTH'(SAMPLE_POST);
    bit_value = (s_lo & s_mid) | (s_lo & rx) | (s_mid & rx);
  end
  always_ff @(posedge clk) begin
    if (rst || !run) cnt <= '0;
    else cnt <= bit_end ? '0 : cnt + PRESCALE_WIDTH'(1);
    if (rst) begin
      s_lo <= 1'b0;
      s_mid <= 1'b0;
    end else begin
      if (run && cnt == half - PRESCALE_WIDTH'(SAMPLE_PRE)) s_lo <= rx;
      if (run && cnt == half) s_mid <= rx;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with run-time frame format and valid/ready holding register
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6,
  parameter int LEN_WIDTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [LEN_WIDTH-1:0]      DATA_LEN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      RX_Data_ready,
  output logic                      RX_Data_valid,
  output logic [MAX_DATA_WIDTH-1:0] RX_P_DATA,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      BRK,
  output logic                      OVR_ERR
);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LEN_MIN = LEN_WIDTH'(MIN_DATA_LEN);
  localparam logic [PRESCALE_WIDTH-1:0] PSC_MIN = PRESCALE_WIDTH'(MIN_PRESCALE);
  state_t state, state_n;
  logic [LEN_WIDTH-1:0] bit_cnt, len_q, len_eff;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_eff;
  logic [MAX_DATA_WIDTH-1:0] shift;
  logic par_en_q, par_typ_q, stop2_q, line_seen_high;
  logic run, bit_valid, bit_value, bit_end, last_stop, deliver, load, start_frame;
  logic par_acc, zero, par_err_p, stp_err_p, brk_p;
  uart_rx_cfg_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .run      (run),
    .rx       (RX_IN),
    .prescale (psc_q),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .bit_end  (bit_end)
  );
  // Prescale is floored so the evaluation point always precedes the bit-end wrap
  always_comb begin
    len_eff = DATA_LEN > LEN_MAX ? LEN_MAX : DATA_LEN < LEN_MIN ? LEN_MIN : DATA_LEN;
    psc_eff = Prescale < PSC_MIN ? PSC_MIN : Prescale;
    run = state inside {START, DATA, PARITY, STOP};
    last_stop = bit_valid && bit_cnt == LEN_WIDTH'(stop2_q);
    deliver = state == DELIVER;
    load = deliver && (!RX_Data_valid || RX_Data_ready);
    start_frame = state == IDLE && state_n == START;
  end
  always_ff @(posedge CLK) state <= RST ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!RX_IN && line_seen_high) state_n = START;
      START:   state_n = (bit_valid && bit_value) ? IDLE : bit_end ? DATA : START;
      DATA:    if (bit_end && bit_cnt == len_q - LEN_WIDTH'(1)) state_n = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (last_stop) state_n = DELIVER;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt <= '0;
      len_q <= '0;
      psc_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q <= 1'b0;
      line_seen_high <= 1'b0;
      shift <= '0;
      par_acc <= 1'b0;
      zero <= 1'b0;
      par_err_p <= 1'b0;
      stp_err_p <= 1'b0;
      brk_p <= 1'b0;
      RX_Data_valid <= 1'b0;
      RX_P_DATA <= '0;
      PAR_ERR <= 1'b0;
      STP_ERR <= 1'b0;
      BRK <= 1'b0;
      OVR_ERR <= 1'b0;
    end else begin
      line_seen_high <= !deliver && (line_seen_high || RX_IN);
      bit_cnt <= state_n != state ? '0 : bit_end ? bit_cnt + LEN_WIDTH'(1) : bit_cnt;
      if (start_frame) begin
        len_q <= len_eff;
        psc_q <= psc_eff;
        par_en_q <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q <= STOP2;
        shift <= '0;
        par_acc <= 1'b0;
        zero <= 1'b1;
        par_err_p <= 1'b0;
        stp_err_p <= 1'b0;
        brk_p <= 1'b0;
      end
      if (bit_valid && state == DATA) begin
        shift <= shift | (MAX_DATA_WIDTH'(bit_value) << bit_cnt);
        par_acc <= par_acc ^ bit_value;
        zero <= zero & ~bit_value;
      end
      if (bit_valid && state == PARITY) begin
        par_err_p <= bit_value != (par_acc ^ par_typ_q);
        zero <= zero & ~bit_value;
      end
      // break needs the first stop bit low on top of an all-zero data/parity field
      if (bit_valid && state == STOP) begin
        stp_err_p <= stp_err_p | ~bit_value;
        if (bit_cnt == '0) brk_p <= zero & ~bit_value;
      end
      OVR_ERR <= deliver && !load;
      if (load) begin
        RX_Data_valid <= 1'b1;
        RX_P_DATA <= shift;
        PAR_ERR <= par_err_p;
        STP_ERR <= stp_err_p;
        BRK <= brk_p;
      end else if (RX_Data_valid && RX_Data_ready) begin
        RX_Data_valid <= 1'b0;
        PAR_ERR <= 1'b0;
        STP_ERR <= 1'b0;
        BRK <= 1'b0;
      end
    end
  end
endmodule
